// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU arbiter: op codes, status flags,
// operand pair and the arbiter FSM state encoding.
package alu_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        add      = 2'b00,
        subtract = 2'b01,
        bitw_or  = 2'b10,
        bitw_and = 2'b11
    } control_e;

    typedef struct packed {
        logic sign;
        logic overflow;
        logic zero;
    } status_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] a;
        logic signed [DATA_W-1:0] b;
    } in_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: add/sub/or/and on a signed operand pair, producing the
// result and {sign, overflow, zero} status. Holds no state.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]         i_op,
    input  logic [2*WIDTH-1:0] i_operands,
    output logic [WIDTH-1:0]   o_result,
    output logic [2:0]         o_status
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_result;
    logic             w_overflow;
    status_t          w_status;

    assign w_a = i_operands[2*WIDTH-1:WIDTH];
    assign w_b = i_operands[WIDTH-1:0];

    // Operation select; overflow only exists for the arithmetic ops
    always_comb begin
        w_result   = {WIDTH{1'b0}};
        w_overflow = 1'b0;
        case (control_e'(i_op))
            add: begin
                w_result   = w_a + w_b;
                w_overflow = (w_a[MSB] == w_b[MSB]) && (w_result[MSB] != w_a[MSB]);
            end
            subtract: begin
                w_result   = w_a - w_b;
                w_overflow = (w_a[MSB] != w_b[MSB]) && (w_result[MSB] != w_a[MSB]);
            end
            bitw_or: begin
                w_result   = w_a | w_b;
                w_overflow = 1'b0;
            end
            bitw_and: begin
                w_result   = w_a & w_b;
                w_overflow = 1'b0;
            end
            default: begin
                w_result   = {WIDTH{1'b0}};
                w_overflow = 1'b0;
            end
        endcase
    end

    // Sign flag is set for a non-negative result
    always_comb begin
        w_status          = 3'b000;
        w_status.sign     = ~w_result[MSB];
        w_status.overflow = w_overflow;
        w_status.zero     = (w_result == {WIDTH{1'b0}});
    end

    assign o_result = w_result;
    assign o_status = w_status;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters;
// owns operand, result and handshake registers (IDLE -> EXEC -> DONE).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid_0,
    output logic               req_ready_0,
    input  logic [1:0]         req_op_0,
    input  logic [2*WIDTH-1:0] req_operands_0,
    output logic               rsp_valid_0,
    input  logic               rsp_ready_0,
    output logic [WIDTH-1:0]   rsp_result_0,
    output logic [2:0]         rsp_status_0,
    input  logic               req_valid_1,
    output logic               req_ready_1,
    input  logic [1:0]         req_op_1,
    input  logic [2*WIDTH-1:0] req_operands_1,
    output logic               rsp_valid_1,
    input  logic               rsp_ready_1,
    output logic [WIDTH-1:0]   rsp_result_1,
    output logic [2:0]         rsp_status_1
);

    arb_state_e         r_state;
    logic               r_last_grant;
    logic               r_owner;
    logic [1:0]         r_op;
    logic [2*WIDTH-1:0] r_operands;
    logic [WIDTH-1:0]   r_result;
    logic [2:0]         r_status;
    logic [1:0]         r_rsp_valid;

    logic [1:0]         w_grant;
    logic [1:0]         w_sel_op;
    logic [2*WIDTH-1:0] w_sel_operands;
    logic               w_owner_ack;
    logic [WIDTH-1:0]   w_alu_result;
    logic [2:0]         w_alu_status;

    // Grant vector (bit i = requester i); a tie goes to the one not served last
    always_comb begin
        w_grant = 2'b00;
        if (r_state == IDLE) begin
            if (req_valid_0 && req_valid_1) begin
                w_grant = r_last_grant ? 2'b01 : 2'b10;
            end else begin
                w_grant = {req_valid_1, req_valid_0};
            end
        end else begin
            w_grant = 2'b00;
        end
    end

    assign w_sel_op       = w_grant[1] ? req_op_1 : req_op_0;
    assign w_sel_operands = w_grant[1] ? req_operands_1 : req_operands_0;
    assign w_owner_ack    = r_owner ? rsp_ready_1 : rsp_ready_0;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .i_op       (r_op),
        .i_operands (r_operands),
        .o_result   (w_alu_result),
        .o_status   (w_alu_status)
    );

    // Arbitration FSM with all datapath and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_op         <= 2'b00;
            r_operands   <= {(2*WIDTH){1'b0}};
            r_result     <= {WIDTH{1'b0}};
            r_status     <= 3'b000;
            r_rsp_valid  <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_op         <= w_sel_op;
                        r_operands   <= w_sel_operands;
                        r_owner      <= w_grant[1];
                        r_last_grant <= w_grant[1];
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    r_result    <= w_alu_result;
                    r_status    <= w_alu_status;
                    r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (w_owner_ack) begin
                        r_rsp_valid <= 2'b00;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 2'b00;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_0  = w_grant[0];
    assign req_ready_1  = w_grant[1];
    assign rsp_valid_0  = r_rsp_valid[0];
    assign rsp_valid_1  = r_rsp_valid[1];
    assign rsp_result_0 = r_result;
    assign rsp_result_1 = r_result;
    assign rsp_status_0 = r_status;
    assign rsp_status_1 = r_status;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// back-pressure / reset sequences and random traffic against a scoreboard.
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [1:0]  req_op_0, req_op_1;
    logic [63:0] req_operands_0, req_operands_1;
    logic        rsp_valid_0, rsp_valid_1;
    logic        rsp_ready_0, rsp_ready_1;
    logic [31:0] rsp_result_0, rsp_result_1;
    logic [2:0]  rsp_status_0, rsp_status_1;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_op_0(req_op_0),
        .req_operands_0(req_operands_0), .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
        .rsp_result_0(rsp_result_0), .rsp_status_0(rsp_status_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_op_1(req_op_1),
        .req_operands_1(req_operands_1), .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
        .rsp_result_1(rsp_result_1), .rsp_status_1(rsp_status_1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: {status, result} from signed 64-bit arithmetic
    function automatic logic [34:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        logic [31:0] res;
        logic ovf;
        logic sgn;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0:    r = sa + sb;
            2'd1:    r = sa - sb;
            2'd2:    r = longint'($signed(a | b));
            default: r = longint'($signed(a & b));
        endcase
        ovf = (op < 2'd2) && (r > 64'sd2147483647 || r < -64'sd2147483648);
        res = r[31:0];
        sgn = ($signed(res) >= 0);
        return {sgn, ovf, (res == 32'd0), res};
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'h0000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input bit who, input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (who) begin
            req_valid_1 = v; req_op_1 = op; req_operands_1 = {a, b};
        end else begin
            req_valid_0 = v; req_op_0 = op; req_operands_0 = {a, b};
        end
    endtask

    function automatic logic ready_of(input bit who);
        return who ? req_ready_1 : req_ready_0;
    endfunction

    function automatic logic rsp_of(input bit who);
        return who ? rsp_valid_1 : rsp_valid_0;
    endfunction

    task automatic set_ack(input bit who, input logic v);
        if (who) rsp_ready_1 = v; else rsp_ready_0 = v;
    endtask

    task automatic wait_ready(input bit who);
        int w;
        w = 0;
        @(negedge clk);
        while (!ready_of(who) && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!ready_of(who)) begin
            total++; bad++;
            $display("FAIL accept_timeout: req%0d ready=0 want 1", who);
        end
    endtask

    // Called at the negedge of the handshake cycle; returns response and latency
    task automatic complete(input bit who, output logic [31:0] res, output logic [2:0] st, output int lat);
        @(posedge clk); #1;
        drive(who, 1'b0, 2'($urandom), $urandom, $urandom);
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_of(who) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = who ? rsp_result_1 : rsp_result_0;
        st  = who ? rsp_status_1 : rsp_status_0;
        if (!rsp_of(who)) begin
            total++; bad++;
            $display("FAIL rsp_timeout: req%0d rsp_valid=0 want 1", who);
        end else begin
            check("other_rsp_valid", 32'(rsp_of(!who)), 32'd0);
            @(posedge clk); #1 set_ack(who, 1'b1);
            @(posedge clk); #1 set_ack(who, 1'b0);
        end
    endtask

    // Scoreboard and protocol monitor, sampled on the falling edge
    typedef struct { bit who; logic [1:0] op; logic [31:0] a; logic [31:0] b; } txn_t;
    txn_t sb[$];
    int   grants[$];
    int   accept_cyc[$];
    int   cyc = 0;
    bit   prev_winner = 1'b1;
    bit   busy = 1'b0;
    bit   both_ready_seen = 1'b0, ready_in_busy = 1'b0, idle_stall = 1'b0, rsp_valid_seen = 1'b0;

    initial begin
        txn_t t;
        logic [34:0] m;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
                prev_winner = 1'b1;
                busy = 1'b0;
            end else begin
                if (req_ready_0 && req_ready_1) both_ready_seen = 1'b1;
                if ((req_ready_0 || req_ready_1) && (rsp_valid_0 || rsp_valid_1)) ready_in_busy = 1'b1;
                if (rsp_valid_0 || rsp_valid_1) rsp_valid_seen = 1'b1;
                if (!busy && (req_valid_0 || req_valid_1) && !(req_ready_0 || req_ready_1)) idle_stall = 1'b1;
                for (int w = 0; w < 2; w++) begin
                    if ((w == 0) ? (req_valid_0 && req_ready_0) : (req_valid_1 && req_ready_1)) begin
                        if (req_valid_0 && req_valid_1)
                            check("rr_tie_winner", 32'(w), 32'(!prev_winner));
                        prev_winner = 1'(w);
                        t.who = 1'(w);
                        t.op  = (w == 0) ? req_op_0 : req_op_1;
                        t.a   = (w == 0) ? req_operands_0[63:32] : req_operands_1[63:32];
                        t.b   = (w == 0) ? req_operands_0[31:0]  : req_operands_1[31:0];
                        sb.push_back(t);
                        grants.push_back(w);
                        accept_cyc.push_back(cyc);
                        busy = 1'b1;
                    end
                end
                for (int w = 0; w < 2; w++) begin
                    if ((w == 0) ? (rsp_valid_0 && rsp_ready_0) : (rsp_valid_1 && rsp_ready_1)) begin
                        if (sb.size() == 0) begin
                            total++; bad++;
                            $display("FAIL sb_unexpected: req%0d response with nothing outstanding", w);
                        end else begin
                            t = sb.pop_front();
                            m = model(t.op, t.a, t.b);
                            check("sb_owner", 32'(w), 32'(t.who));
                            check("sb_result", (w == 0) ? rsp_result_0 : rsp_result_1, m[31:0]);
                            check("sb_status", 32'((w == 0) ? rsp_status_0 : rsp_status_1), 32'(m[34:32]));
                        end
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    typedef struct { bit who; logic [1:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp_res; logic [2:0] exp_st; } vec_t;
    localparam int NV = 9;
    vec_t vecs[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res, hold_res;
        logic [2:0]  st, hold_st;
        logic [34:0] m;
        int lat;
        bit stable, r1_blocked;

        vecs[0] = '{1'b0, add,      32'd5,        32'hFFFF_FFF9, 32'hFFFF_FFFE, 3'b000};
        vecs[1] = '{1'b1, add,      32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 3'b010};
        vecs[2] = '{1'b1, subtract, 32'd3,        32'd3,         32'h0000_0000, 3'b101};
        vecs[3] = '{1'b1, bitw_or,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 3'b100};
        vecs[4] = '{1'b0, bitw_and, 32'h0000_00F0, 32'h0000_000F, 32'h0000_0000, 3'b101};
        vecs[5] = '{1'b0, subtract, 32'h8000_0000, 32'd1,        32'h7FFF_FFFF, 3'b110};
        vecs[6] = '{1'b1, add,      32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 3'b101};
        vecs[7] = '{1'b0, bitw_and, 32'hFFFF_0000, 32'hF0F0_F0F0, 32'hF0F0_0000, 3'b000};
        vecs[8] = '{1'b1, subtract, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 3'b010};

        rst = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
        rsp_ready_0 = 1'b0;
        rsp_ready_1 = 1'b0;

        // Reset state, then first-tie readiness with only requester 0 valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid_0", 32'(rsp_valid_0), 32'd0);
        check("rst_rsp_valid_1", 32'(rsp_valid_1), 32'd0);
        check("rst_result", rsp_result_0, 32'd0);
        check("rst_status", 32'(rsp_status_1), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b1, add, 32'd5, 32'hFFFF_FFF9);
        @(negedge clk);
        check("rst_ready_0", 32'(req_ready_0), 32'd1);
        check("rst_ready_1", 32'(req_ready_1), 32'd0);
        complete(1'b0, res, st, lat);
        check("first_add_result", res, 32'hFFFF_FFFE);
        check("first_add_latency", 32'(lat), 32'd2);

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].who, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            wait_ready(vecs[i].who);
            complete(vecs[i].who, res, st, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d_status", i), 32'(st), 32'(vecs[i].exp_st));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        end

        // Response back-pressure on requester 0 while requester 1 waits
        drive(1'b0, 1'b1, subtract, 32'd100, 32'd250);
        wait_ready(1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, bitw_or, $urandom, $urandom);
        drive(1'b1, 1'b1, bitw_or, 32'h1234_0000, 32'h0000_5678);
        lat = 1;
        @(negedge clk);
        while (!rsp_valid_0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd2);
        hold_res = rsp_result_0;
        hold_st  = rsp_status_0;
        m = model(subtract, 32'd100, 32'd250);
        check("bp_result", hold_res, m[31:0]);
        check("bp_status", 32'(hold_st), 32'(m[34:32]));
        stable = 1'b1;
        r1_blocked = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!rsp_valid_0 || rsp_result_0 !== hold_res || rsp_status_0 !== hold_st) stable = 1'b0;
            if (req_ready_1) r1_blocked = 1'b0;
        end
        check("bp_hold_stable", 32'(stable), 32'd1);
        check("bp_req1_blocked", 32'(r1_blocked), 32'd1);
        @(posedge clk); #1 rsp_ready_0 = 1'b1;
        @(posedge clk); #1 rsp_ready_0 = 1'b0;
        @(negedge clk);
        check("bp_release_ready_1", 32'(req_ready_1), 32'd1);
        check("bp_release_rsp_valid_0", 32'(rsp_valid_0), 32'd0);
        complete(1'b1, res, st, lat);
        check("bp_req1_result", res, 32'h1234_5678);

        // Saturated round-robin after reset, random payload every cycle
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        grants.delete();
        accept_cyc.delete();
        @(posedge clk); #1 rst = 1'b0;
        rsp_ready_0 = 1'b1;
        rsp_ready_1 = 1'b1;
        repeat (60) begin
            drive(1'b0, 1'b1, 2'($urandom), rand_word(), rand_word());
            drive(1'b1, 1'b1, 2'($urandom), rand_word(), rand_word());
            @(posedge clk); #1;
        end
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rr_accept_count", 32'(grants.size() >= 18), 32'd1);
        for (int i = 0; i < grants.size(); i++) begin
            check($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));
            if (i > 0) check($sformatf("rr_interval%0d", i), 32'(accept_cyc[i] - accept_cyc[i-1]), 32'd3);
        end

        // Random valids and response back-pressure, scoreboard checked
        repeat (400) begin
            req_valid_0 = ($urandom_range(0, 3) != 0);
            req_valid_1 = ($urandom_range(0, 3) != 0);
            req_op_0 = 2'($urandom);
            req_op_1 = 2'($urandom);
            req_operands_0 = {rand_word(), rand_word()};
            req_operands_1 = {rand_word(), rand_word()};
            rsp_ready_0 = 1'($urandom);
            rsp_ready_1 = 1'($urandom);
            @(posedge clk); #1;
        end
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        rsp_ready_0 = 1'b1;
        rsp_ready_1 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rand_drained", 32'(sb.size()), 32'd0);
        rsp_ready_0 = 1'b0;
        rsp_ready_1 = 1'b0;

        // Reset pulse while requester 0's operation is in EXEC
        drive(1'b0, 1'b1, add, 32'd11, 32'd22);
        wait_ready(1'b0);
        @(posedge clk); #1;
        req_valid_0 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_valid_seen = 1'b0;
        rsp_ready_0 = 1'b1;
        rsp_ready_1 = 1'b1;
        repeat (6) @(negedge clk);
        check("midop_no_rsp", 32'(rsp_valid_seen), 32'd0);
        rsp_ready_0 = 1'b0;
        rsp_ready_1 = 1'b0;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, bitw_and, 32'h0F0F_0F0F, 32'hFFFF_00FF);
        drive(1'b1, 1'b1, add, 32'd1, 32'd1);
        @(negedge clk);
        check("midop_tie_ready_0", 32'(req_ready_0), 32'd1);
        check("midop_tie_ready_1", 32'(req_ready_1), 32'd0);
        complete(1'b0, res, st, lat);
        check("midop_next_result", res, 32'h0F0F_000F);
        check("midop_next_latency", 32'(lat), 32'd2);

        check("never_both_ready", 32'(both_ready_seen), 32'd0);
        check("no_ready_while_rsp", 32'(ready_in_busy), 32'd0);
        check("no_idle_stall", 32'(idle_stall), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU between two requesters. Each requester issues an operation (op code plus two signed 32-bit operands) over a valid/ready handshake. The block arbitrates round-robin, registers the operands, evaluates the ALU and returns the result plus status flags to the winning requester over a response valid/ready handshake. It sits between the two issue stages and the shared ALU datapath, and uses the types in `alu_pkg`.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; must match `alu_pkg::in_t` fields.

Ports, requester `i` ∈ {0,1}:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  1  requester `i` has an operation.
- `req_ready_i`  out  1  operation accepted this cycle when high with `req_valid_i`.
- `req_op_i`  in  2  `alu_pkg::control_e` op code.
- `req_operands_i`  in  2×WIDTH  `alu_pkg::in_t` {a, b}, signed.
- `rsp_valid_i`  out  1  result for requester `i` is held.
- `rsp_ready_i`  in  1  requester `i` consumes the result.
- `rsp_result_i`  out  WIDTH  ALU result.
- `rsp_status_i`  out  3  `alu_pkg::status_t` {sign, overflow, zero}.

## Operation
- FSM states:
  - `IDLE`: `req_ready_i` = grant_i, combinational from valids and `last_grant`. On a handshake, latch op, operands and owner; set `last_grant` = owner; go to `EXEC`.
  - `EXEC`: ALU evaluates the latched operands; register result and status; go to `DONE`.
  - `DONE`: `rsp_valid_owner` = 1. On `rsp_ready_owner`, go to `IDLE`. Otherwise hold all outputs stable.
- Arbitration:
  - One valid requester: it wins.
  - Both valid: the winner is the requester ≠ `last_grant`.
  - `req_ready_i` is never high outside `IDLE`, and never for both requesters.
- Arithmetic:
  - `add`: a+b, modulo 2^WIDTH.
  - `subtract`: a−b, modulo 2^WIDTH.
  - `bitw_or`: a|b.
  - `bitw_and`: a&b.
- Status flags:
  - overflow: signed overflow for add/sub, i.e. operand signs (b inverted for sub) equal and result sign differs. Always 0 for or/and.
  - zero = (result == 0).
  - sign = ~result[WIDTH-1], asserted when the result is non-negative (positive or zero).
- Non-owner outputs: `rsp_valid` = 0 at all times. Result/status ports are driven to the same registered values for both requesters.
- Requester payload may change while `req_ready_i` = 0; only the handshake cycle is sampled.

## Timing
- Reset values:
  - state `IDLE`, `last_grant` = 1, so requester 0 wins the first tie.
  - all `rsp_valid` = 0, result = 0, status = {0,0,0}.
  - `req_ready` follows from `IDLE` and the current valids.
- Latency: handshake in cycle N → `rsp_valid` high from cycle N+2.
- Minimum initiation interval is 3 cycles: `DONE` with `rsp_ready` in N+2 → `IDLE` in N+3, next accept in N+3.
- Response back-pressure: `rsp_valid` stays high and data stays stable until `rsp_ready`; no accepts occur meanwhile.
- `rsp_ready` while `rsp_valid` = 0: ignored.
- Reset mid-operation (`EXEC` or `DONE`): the transaction is dropped, no response is issued, and the next cycle is `IDLE` with reset values.
- A requester that deasserts valid before its grant loses nothing; arbitration is re-evaluated every `IDLE` cycle.

## Structure
- `alu_pkg` holds `control_e`, `status_t`, `in_t`. Add the FSM state enum `arb_state_e` {IDLE, EXEC, DONE} there.
- One sub-module `alu_core`: purely combinational, (op, in_t) → (result, status_t). The arbiter owns all registers.
- `last_grant` is 1 bit; owner is 1 bit.

## Test plan
- Reset: assert `rst` for 2 cycles → `rsp_valid_0/1` = 0, result 0, status {0,0,0}; `req_ready_0` = 1 the cycle after release with only `req_valid_0` high.
- Single add: requester 0 issues add a=5, b=−7 in cycle N → `rsp_valid_0` in N+2, result −2, status {sign 0, overflow 0, zero 0}.
- Overflow/zero: requester 1 issues add 0x7FFFFFFF+1 → result 0x80000000, overflow 1, sign 0. Then sub 3−3 → result 0, zero 1, sign 1. Then or 0xF0|0x0F → 0xFF, overflow 0.
- Round-robin: both valid continuously with `rsp_ready` tied high → grants alternate 0,1,0,1, starting with 0. Accepts occur every 3 cycles; `req_ready` is never high for both.
- Back-pressure: hold `rsp_ready_0` = 0 for 5 cycles after the response appears → result and status stable, `req_ready_1` = 0 throughout. Release → `IDLE` next cycle and requester 1 is granted.
- Reset mid-op: pulse `rst` in `EXEC` → no `rsp_valid` appears, `last_grant` reverts so requester 0 wins the next tie.
